// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access sequencer: ops, address-mux selects,
// FSM states and the latched request payload.
package dmem_access_ctrl_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned SP_W  = 8;
  localparam int unsigned CNT_W = 3;

  localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
  localparam logic [OP_W-1:0] OP_LOAD  = 3'd1;
  localparam logic [OP_W-1:0] OP_STORE = 3'd2;
  localparam logic [OP_W-1:0] OP_PUSH  = 3'd3;
  localparam logic [OP_W-1:0] OP_POP   = 3'd4;
  localparam logic [OP_W-1:0] OP_SPRST = 3'd5;

  localparam logic [SEL_W-1:0] SEL_B    = 2'b00;
  localparam logic [SEL_W-1:0] SEL_A    = 2'b01;
  localparam logic [SEL_W-1:0] SEL_K    = 2'b10;
  localparam logic [SEL_W-1:0] SEL_ZERO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_CAPTURE
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [SEL_W-1:0] src_sel;
  } req_t;

  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > OP_SPRST;
  endfunction

endpackage

// File: rtl/dmem_sp_reg.sv
// Stack pointer register with increment/decrement/reload and the empty/full compares
// used for push/pop fault detection.
module dmem_sp_reg
  import dmem_access_ctrl_pkg::*;
#(
  parameter logic [SP_W-1:0] SP_RESET = 8'hFF,
  parameter logic [SP_W-1:0] SP_LIMIT = 8'h80
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            dec,
  input  logic            load,
  output logic [SP_W-1:0] sp,
  output logic            at_limit_c,
  output logic            at_reset_c
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= SP_RESET;
    end else if (load) begin
      sp <= SP_RESET;
    end else if (inc) begin
      sp <= sp + SP_W'(1);
    end else if (dec) begin
      sp <= sp - SP_W'(1);
    end
  end

  assign at_limit_c = (sp == SP_LIMIT);
  assign at_reset_c = (sp == SP_RESET);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: accepts one op at a time, drives address select and
// memory strobes, owns the stack pointer and reports completion/faults with done/err.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter logic [SP_W-1:0] SP_RESET = 8'hFF,
  parameter logic [SP_W-1:0] SP_LIMIT = 8'h80,
  parameter int unsigned     MEM_LAT  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [SEL_W-1:0] src_sel,
  output logic [SEL_W-1:0] mux_sel,
  output logic             sp_addr_en,
  output logic [SP_W-1:0]  sp,
  output logic             mem_we,
  output logic             mem_re,
  output logic             rd_capture,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);

  state_e            state, state_d;
  req_t              req_q;
  logic              fault_q, fault_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic              sp_inc, sp_dec, sp_load;
  logic              at_limit_c, at_reset_c;
  logic              is_pop_q, is_read_q;
  logic [SEL_W-1:0]  mux_d;
  logic              spa_d, we_d, re_d, cap_d, done_d, err_d, rdy_d;

  dmem_sp_reg #(
    .SP_RESET (SP_RESET),
    .SP_LIMIT (SP_LIMIT)
  ) u_sp (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (sp_inc),
    .dec        (sp_dec),
    .load       (sp_load),
    .sp         (sp),
    .at_limit_c (at_limit_c),
    .at_reset_c (at_reset_c)
  );

  assign accept    = (state == ST_IDLE) && req_valid;
  assign fault_c   = op_illegal(op) || (op == OP_PUSH && at_limit_c) || (op == OP_POP && at_reset_c);
  assign is_pop_q  = (req_q.op == OP_POP);
  assign is_read_q = !fault_q && (req_q.op == OP_LOAD || is_pop_q);

  // Next state plus the registered output values for the following cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    mux_d   = SEL_ZERO;
    spa_d   = 1'b0;
    we_d    = 1'b0;
    re_d    = 1'b0;
    cap_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdy_d   = 1'b0;
    sp_inc  = 1'b0;
    sp_dec  = 1'b0;
    sp_load = 1'b0;
    unique case (state)
      ST_IDLE: begin
        rdy_d = 1'b1;
        if (req_valid) begin
          state_d = ST_ACCESS;
          rdy_d   = 1'b0;
          if (fault_c) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            case (op)
              OP_LOAD:  begin mux_d = src_sel; re_d = 1'b1; end
              OP_STORE: begin mux_d = src_sel; we_d = 1'b1; done_d = 1'b1; end
              OP_PUSH:  begin spa_d = 1'b1; we_d = 1'b1; done_d = 1'b1; end
              OP_POP:   begin spa_d = 1'b1; re_d = 1'b1; sp_inc = 1'b1; end
              default:  done_d = 1'b1;
            endcase
          end
        end
      end
      ST_ACCESS: begin
        if (is_read_q) begin
          cnt_d = '0;
          if (is_pop_q) spa_d = 1'b1;
          else          mux_d = req_q.src_sel;
          if (MEM_LAT == 1) begin
            state_d = ST_CAPTURE;
            cap_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
          rdy_d   = 1'b1;
          sp_dec  = !fault_q && (req_q.op == OP_PUSH);
          sp_load = !fault_q && (req_q.op == OP_SPRST);
        end
      end
      ST_WAIT: begin
        if (is_pop_q) spa_d = 1'b1;
        else          mux_d = req_q.src_sel;
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_CAPTURE;
          cap_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
        rdy_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      fault_q    <= 1'b0;
      mux_sel    <= SEL_ZERO;
      sp_addr_en <= 1'b0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      rd_capture <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      state      <= state_d;
      cnt_q      <= cnt_d;
      if (accept) begin
        req_q   <= '{op: op, src_sel: src_sel};
        fault_q <= fault_c;
      end
      mux_sel    <= mux_d;
      sp_addr_en <= spa_d;
      mem_we     <= we_d;
      mem_re     <= re_d;
      rd_capture <= cap_d;
      done       <= done_d;
      err        <= err_d;
      req_ready  <= rdy_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench: two sequencers (read latency 1 and 3) driven with directed and random
// ops; a transaction-level stack model predicts each op's response for the monitor.
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n_w, req_valid, req_ready_w, spa_w, we_w, re_w, cap_w, done_w, err_w;
  logic [1:0][2:0] op_w;
  logic [1:0][1:0] src_w, mux_w;
  logic [1:0][7:0] sp_w;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_access_ctrl #(
      .SP_RESET (8'hFF),
      .SP_LIMIT (8'h80),
      .MEM_LAT  (g == 0 ? 1 : 3)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n_w[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready_w[g]),
      .op         (op_w[g]),
      .src_sel    (src_w[g]),
      .mux_sel    (mux_w[g]),
      .sp_addr_en (spa_w[g]),
      .sp         (sp_w[g]),
      .mem_we     (we_w[g]),
      .mem_re     (re_w[g]),
      .rd_capture (cap_w[g]),
      .done       (done_w[g]),
      .err        (err_w[g])
    );
  end

  typedef struct {
    int         lat;
    logic       err;
    int         n_we, n_re, n_cap;
    logic       chk;
    logic       spa;
    logic [1:0] sel;
    logic [7:0] asp;
    logic [7:0] sp_after;
  } exp_t;

  typedef struct {
    bit         busy, first, held_bad, rdy_bad, pend;
    int         acc, nwe, nre, ncap;
    logic [1:0] sel0;
    logic       spa0;
    logic [7:0] asp, sp_exp;
  } mon_t;

  exp_t       sb0[$], sb1[$];
  mon_t       ms[2];
  logic [7:0] sp_m[2];
  int         vectors = 0, miscompares = 0, cyc = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int i, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, expv, $time);
    end
  endtask

  // Stack-machine view of one op: what the sequencer must report and where sp ends up.
  function automatic exp_t model(input int i, input logic [2:0] o, input logic [1:0] s);
    exp_t e;
    logic [7:0] cur = sp_m[i];
    bit bad = (o > 3'd5) || (o == 3'd3 && cur == 8'h80) || (o == 3'd4 && cur == 8'hFF);
    bit rd  = !bad && (o == 3'd1 || o == 3'd4);
    bit wr  = !bad && (o == 3'd2 || o == 3'd3);
    e.lat   = rd ? 1 + lat_of(i) : 1;
    e.err   = bad;
    e.n_we  = wr ? 1 : 0;
    e.n_re  = rd ? 1 : 0;
    e.n_cap = rd ? 1 : 0;
    e.chk   = !bad && o >= 3'd1 && o <= 3'd4;
    e.spa   = (o == 3'd3 || o == 3'd4);
    e.sel   = s;
    e.asp   = (o == 3'd4) ? cur + 8'd1 : cur;
    if (bad)            e.sp_after = cur;
    else if (o == 3'd3) e.sp_after = cur - 8'd1;
    else if (o == 3'd4) e.sp_after = cur + 8'd1;
    else if (o == 3'd5) e.sp_after = 8'hFF;
    else                e.sp_after = cur;
    return e;
  endfunction

  task automatic mon_step(input int i);
    mon_t m = ms[i];
    exp_t e;
    bit   have = 0;
    if (!rst_n_w[i]) begin
      ms[i] = '{default: 0};
      return;
    end
    if (m.pend) begin
      chk("sp_after", i, int'(sp_w[i]), int'(m.sp_exp));
      m.pend = 0;
    end
    if (m.busy) begin
      if (m.first) begin
        m.sel0 = mux_w[i]; m.spa0 = spa_w[i]; m.first = 0;
      end else if (mux_w[i] != m.sel0 || spa_w[i] != m.spa0) begin
        m.held_bad = 1;
      end
      if (req_ready_w[i]) m.rdy_bad = 1;
      if (we_w[i])  begin m.nwe++; m.asp = sp_w[i]; end
      if (re_w[i])  begin m.nre++; m.asp = sp_w[i]; end
      if (cap_w[i]) m.ncap++;
      if (done_w[i]) begin
        if (i == 0) begin have = sb0.size() > 0; if (have) e = sb0.pop_front(); end
        else        begin have = sb1.size() > 0; if (have) e = sb1.pop_front(); end
        if (!have) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_done dut%0d: got done with empty scoreboard at %0t", i, $time);
        end else begin
          chk("latency", i, cyc - m.acc, e.lat);
          chk("err", i, int'(err_w[i]), int'(e.err));
          chk("we_count", i, m.nwe, e.n_we);
          chk("re_count", i, m.nre, e.n_re);
          chk("capture_count", i, m.ncap, e.n_cap);
          chk("ready_low_busy", i, int'(m.rdy_bad), 0);
          if (e.chk) begin
            chk("sp_addr_en", i, int'(m.spa0), int'(e.spa));
            chk("addr_held", i, int'(m.held_bad), 0);
            if (e.spa) chk("stack_addr", i, int'(m.asp), int'(e.asp));
            else       chk("mux_sel", i, int'(m.sel0), int'(e.sel));
          end
          m.pend = 1; m.sp_exp = e.sp_after;
        end
        m.busy = 0;
      end else if (cyc - m.acc > 20) begin
        vectors++; miscompares++;
        $display("FAIL done_timeout dut%0d: no done %0d cycles after accept", i, cyc - m.acc);
        m.busy = 0;
      end
    end else begin
      chk("idle_outputs", i,
          int'({we_w[i], re_w[i], cap_w[i], done_w[i], spa_w[i], mux_w[i], req_ready_w[i]}), 8'h07);
      if (req_valid[i]) begin
        m.busy = 1; m.first = 1; m.acc = cyc; m.held_bad = 0; m.rdy_bad = 0;
        m.nwe = 0; m.nre = 0; m.ncap = 0;
      end
    end
    ms[i] = m;
  endtask

  initial begin
    ms[0] = '{default: 0};
    ms[1] = '{default: 0};
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) mon_step(i);
    end
  end

  // Presents one op at posedge+1 and returns just after the accepting edge.
  task automatic issue(input int i, input logic [2:0] o, input logic [1:0] s);
    exp_t e = model(i, o, s);
    int   n = 0;
    if (i == 0) sb0.push_back(e); else sb1.push_back(e);
    sp_m[i]      = e.sp_after;
    op_w[i]      = o;
    src_w[i]     = s;
    req_valid[i] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready_w[i] && n < 64);
    if (!req_ready_w[i]) begin
      miscompares++;
      $display("FAIL accept_timeout dut%0d: req_ready low for %0d cycles", i, n);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "sequencer never became ready");
    end
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    op_w[i]      = 3'($urandom_range(0, 7));
    src_w[i]     = 2'($urandom_range(0, 3));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_inst(input int i);
    issue(i, 3'd1, 2'b10);
    issue(i, 3'd3, 2'b00);
    issue(i, 3'd4, 2'b01);
    issue(i, 3'd4, 2'b00);
    issue(i, 3'd7, 2'b00);
    issue(i, 3'd2, 2'b00);
    issue(i, 3'd6, 2'b11);
    issue(i, 3'd0, 2'b01);
    issue(i, 3'd3, 2'b00);
    issue(i, 3'd5, 2'b00);
    for (int n = 0; n < 120; n++) begin
      issue(i, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      idle($urandom_range(0, 2));
    end
    issue(i, 3'd5, 2'b00);
    for (int n = 0; n < 127; n++) issue(i, 3'd3, 2'($urandom_range(0, 3)));
    issue(i, 3'd3, 2'b00);
    issue(i, 3'd4, 2'b00);
    issue(i, 3'd3, 2'b00);
    issue(i, 3'd3, 2'b00);
    idle(4);
  endtask

  initial begin
    rst_n_w   = 2'b00;
    req_valid = 2'b00;
    op_w      = '0;
    src_w     = '0;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("reset_outputs", i,
          int'({we_w[i], re_w[i], cap_w[i], done_w[i], err_w[i], spa_w[i], mux_w[i]}), 7'b0000011);
      chk("reset_sp", i, int'(sp_w[i]), 8'hFF);
      sp_m[i] = 8'hFF;
    end
    @(posedge clk);
    #1;
    rst_n_w = 2'b11;
    idle(2);

    run_inst(0);
    run_inst(1);

    // Reset dropped while a latency-3 read sits in WAIT.
    issue(1, 3'd5, 2'b00);
    issue(1, 3'd3, 2'b00);
    issue(1, 3'd1, 2'b01);
    @(posedge clk);
    #1;
    rst_n_w[1] = 1'b0;
    #1;
    chk("reset_strobes", 1, int'({we_w[1], re_w[1], cap_w[1], done_w[1]}), 0);
    chk("reset_abort_sp", 1, int'(sp_w[1]), 8'hFF);
    sb1.delete();
    sp_m[1] = 8'hFF;
    idle(2);
    rst_n_w[1] = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 1, int'(req_ready_w[1]), 1);
    @(posedge clk);
    #1;
    issue(1, 3'd1, 2'b00);
    issue(1, 3'd4, 2'b00);
    idle(10);

    chk("scoreboard_drained", 0, sb0.size(), 0);
    chk("scoreboard_drained", 1, sb1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
